// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state encoding, a ceiling-log2 helper and default widths.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so that index ports always have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int PTR_W         = clog2(DEF_NREQ);
  localparam int BCNT_W        = clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request
// bit found scanning upward from ptr, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        idx   = ID_W'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the single push port of an async FIFO.
// Optional burst mode is enabled by defining FIFO_WR_ARB_BURST_EN; without it
// the grant rotates after every pushed word.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; arbitrate among i_req starting from ptr
//   BUSY  | owner drives push/data; stalls on i_full, leaves on drop/limit
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*WIDTH-1:0]    i_data,
  output logic [NREQ-1:0]          o_ack,
  input  logic                     i_full,
  output logic                     o_push,
  output logic [WIDTH-1:0]         o_wdata,
  output logic [clog2(NREQ)-1:0]   o_grant_id,
  output logic                     o_busy
);

  localparam int             ID_W    = clog2(NREQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  generate
    if (NREQ < 2) begin : g_bad_nreq
      $error("fifo_wr_arbiter: NREQ must be at least 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
      $error("fifo_wr_arbiter: MAX_BURST must be at least 1");
    end
  endgenerate

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_nxt;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            exit_now;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int               BC_W       = clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST);
  logic [BC_W-1:0] bcnt_q, bcnt_d;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Pointer for the next arbitration: one past the current owner, wrapping.
  assign owner_nxt = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

  // Next-state logic plus the push-side outputs, which stay combinational
  // so that the FIFO's own full flag gates the push in the same cycle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    o_push   = 1'b0;
    o_ack    = '0;
    o_wdata  = '0;
    exit_now = 1'b0;
`ifdef FIFO_WR_ARB_BURST_EN
    bcnt_d   = bcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = BUSY;
`ifdef FIFO_WR_ARB_BURST_EN
          bcnt_d  = '0;
`endif
        end
      end
      BUSY: begin
        o_push         = i_req[owner_q] & ~i_full;
        o_wdata        = i_data[int'(owner_q)*WIDTH +: WIDTH];
        o_ack[owner_q] = o_push;
`ifdef FIFO_WR_ARB_BURST_EN
        if (o_push) bcnt_d = bcnt_q + BC_W'(1);
        exit_now = ~i_req[owner_q] | (o_push & ((bcnt_q + BC_W'(1)) == BURST_LAST));
`else
        exit_now = ~i_req[owner_q] | o_push;
`endif
        if (exit_now) begin
          state_d = IDLE;
          ptr_d   = owner_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, round-robin pointer and burst count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef FIFO_WR_ARB_BURST_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef FIFO_WR_ARB_BURST_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign o_grant_id = owner_q;
  assign o_busy     = (state_q == BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-free behavioural model of the arbiter rules.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 16;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int LIMIT = MAX_BURST;
`else
  localparam int LIMIT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic                  full = 1'b0;
  logic [NREQ-1:0]       ack;
  logic                  push;
  logic [WIDTH-1:0]      wdata;
  logic [1:0]            gid;
  logic                  busy;

  int tests = 0;
  int fails = 0;

  logic [NREQ-1:0] last_ack = '0;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_data     (data),
    .o_ack      (ack),
    .i_full     (full),
    .o_push     (push),
    .o_wdata    (wdata),
    .o_grant_id (gid),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    data  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_push(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      #2;
      if (push) ok = 1'b1;
    end
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
  endtask

  // Behavioural model: who owns the port, where the search starts next and
  // how many words the owner has pushed; outputs follow from those plus inputs.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0]  e_ack;
    logic             e_push;
    logic [WIDTH-1:0] e_wd;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      last_ack = '0;
      chk("rst_push", 64'(push), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_gid", 64'(gid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      e_push = m_busy && req[m_owner] && !full;
      e_ack  = '0;
      if (e_push) e_ack[m_owner] = 1'b1;
      e_wd   = m_busy ? data[m_owner*WIDTH +: WIDTH] : '0;
      chk("push", 64'(push), 64'(e_push));
      chk("ack", 64'(ack), 64'(e_ack));
      chk("wdata", 64'(wdata), 64'(e_wd));
      chk("grant_id", 64'(gid), 64'(m_owner));
      chk("busy", 64'(busy), 64'(m_busy));
      last_ack = e_ack;
      if (!m_busy) begin
        if (req != '0) begin
          for (int i = 0; i < NREQ; i++) begin
            if (req[(m_ptr + i) % NREQ]) begin
              m_owner = (m_ptr + i) % NREQ;
              break;
            end
          end
          m_cnt  = 0;
          m_busy = 1'b1;
        end
      end else begin
        if (e_push) m_cnt++;
        if (!req[m_owner] || (e_push && m_cnt == LIMIT)) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NREQ;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gap;
    bit got;

    // Reset values.
    step();
    #2;
    chk("reset_push", 64'(push), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_gid", 64'(gid), 64'd0);
    step();
    rst_n = 1'b1;

    // Single requester 2: words 0x0011 then 0x0022.
    req = 4'b0100;
    data[2*WIDTH +: WIDTH] = 16'h0011;
    step();
    #2;
    chk("single_push1", 64'(push), 64'd1);
    chk("single_wdata1", 64'(wdata), 64'h0011);
    chk("single_ack1", 64'(ack), 64'b0100);
    chk("single_gid1", 64'(gid), 64'd2);
    gap = 0;
    got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      step();
      if (i == 1) data[2*WIDTH +: WIDTH] = 16'h0022;
      #2;
      if (push) begin got = 1'b1; gap = i; end
    end
    chk("single_gap", 64'(gap), (LIMIT > 1) ? 64'd1 : 64'd2);
    chk("single_wdata2", 64'(wdata), 64'h0022);
    chk("single_ack2", 64'(ack), 64'b0100);
    chk("single_gid2", 64'(gid), 64'd2);

    // All four requesting: grant order follows round-robin per limit.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) data[k*WIDTH +: WIDTH] = 16'(16'h1000 + k);
    for (int n = 0; n < 8; n++) begin
      wait_push(ok);
      chk("rr_order", 64'(gid), 64'((n / LIMIT) % NREQ));
      chk("rr_wdata", 64'(wdata), 64'(16'h1000 + (n / LIMIT) % NREQ));
    end

    // Full stall after two pushes, then remaining words resume.
    do_reset();
    req = 4'b0011;
    data[0 +: WIDTH] = 16'hA000;
    data[WIDTH +: WIDTH] = 16'hB000;
    wait_push(ok);
    wait_push(ok);
    for (int i = 0; i < 3; i++) begin
      step();
      full = 1'b1;
      #2;
      chk("stall_push", 64'(push), 64'd0);
      chk("stall_ack", 64'(ack), 64'd0);
      if (i > 0) begin
        chk("stall_gid", 64'(gid), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
      end
    end
    step();
    full = 1'b0;
    #2;
    if (!push) wait_push(ok);
    chk("resume_gid0", 64'(gid), 64'((2 / LIMIT) % 2));
    for (int n = 3; n < 5; n++) begin
      wait_push(ok);
      chk("resume_gid", 64'(gid), 64'((n / LIMIT) % 2));
    end

    // Owner drops request in the cycle full rises.
    do_reset();
    req = 4'b0010;
    step();
    req  = 4'b0000;
    full = 1'b1;
    #2;
    chk("drop_push", 64'(push), 64'd0);
    chk("drop_ack", 64'(ack), 64'd0);
    chk("drop_busy", 64'(busy), 64'd1);
    chk("drop_gid", 64'(gid), 64'd1);
    step();
    #2;
    chk("drop_idle", 64'(busy), 64'd0);
    req  = 4'b1111;
    full = 1'b0;
    step();
    #2;
    chk("drop_next_busy", 64'(busy), 64'd1);
    chk("drop_next_gid", 64'(gid), 64'd2);

    // Reset asserted while a word is being pushed.
    do_reset();
    req = 4'b0011;
    wait_push(ok);
    wait_push(ok);
    rst_n = 1'b0;
    #1;
    chk("midrst_push", 64'(push), 64'd0);
    chk("midrst_ack", 64'(ack), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    #2;
    chk("midrst_regrant_busy", 64'(busy), 64'd1);
    chk("midrst_regrant_gid", 64'(gid), 64'd0);

    // Randomized traffic; requesters advance data when acked.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int k = 0; k < NREQ; k++) begin
        if (req[k] && last_ack[k]) begin
          data[k*WIDTH +: WIDTH] = 16'($urandom);
          req[k] = ($urandom_range(0, 9) < 7);
        end else if (!req[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[k] = 1'b1;
            data[k*WIDTH +: WIDTH] = 16'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[k] = 1'b0;
        end
      end
      full = ($urandom_range(0, 3) == 0);
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write (push) port of an `async_fifo` between NREQ requesters in the write-clock domain. Each requester holds a request with its data word. The arbiter grants one owner at a time, drives the FIFO push/data lines, honours `o_full` backpressure and acknowledges each accepted word. An optional burst mode lets an owner push several consecutive words before the grant rotates.

## Interface
- WIDTH, 16, data word width; must equal the FIFO WIDTH.
- NREQ, 4, number of requesters; legal range ≥ 2.
- MAX_BURST, 4, maximum words per grant in burst mode; legal range ≥ 1; unused when burst mode is compiled out.

Ports:
- i_clk  in  1  single clock; the FIFO write clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  NREQ  per-requester request; held high while the requester has a word on its i_data slice.
- i_data  in  NREQ*WIDTH  requester words; slice k is bits [k*WIDTH +: WIDTH].
- o_ack  out  NREQ  one-hot; high in the cycle requester k's word is pushed; the requester advances its data on this cycle.
- i_full  in  1  FIFO `o_full`.
- o_push  out  1  FIFO `i_push`.
- o_wdata  out  WIDTH  FIFO `i_wdata`.
- o_grant_id  out  clog2(NREQ)  current or last owner index.
- o_busy  out  1  high while in BUSY.

## Operation
- FSM has two states: IDLE and BUSY. Registers are state, owner (= o_grant_id), round-robin pointer `ptr` and burst counter `bcnt`.
- IDLE:
  - If any i_req bit is set, pick the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Register it as owner, clear bcnt and go to BUSY.
  - With no requests, stay in IDLE; ptr is unchanged.
- BUSY:
  - o_push = i_req[owner] & ~i_full.
  - o_wdata = i_data[owner] (combinational mux on the registered owner).
  - o_ack[owner] = o_push; all other ack bits are 0.
  - Each push increments bcnt.
- BUSY exit occurs at the clock edge where either of these holds:
  - i_req[owner] == 0; or
  - a push occurs with bcnt+1 == burst limit. The limit is MAX_BURST in burst mode, else 1.
- On exit: next state = IDLE and ptr = owner+1 modulo NREQ.
- Full stall: while i_full=1 the owner keeps the grant, bcnt holds and there is no push or ack. There is no timeout.
- Simultaneous events:
  - If i_req[owner] drops in the same cycle i_full rises, no push occurs and BUSY exits.
  - New requests arriving during BUSY wait for the next IDLE.
- Outside BUSY: o_push=0, o_ack=0, o_wdata=0.

## Timing
- Reset values: state=IDLE, owner=0, ptr=0, bcnt=0. Outputs: o_push=0, o_ack=0, o_wdata=0, o_grant_id=0, o_busy=0.
- Reset asserted mid-burst forces all outputs to reset values immediately (asynchronously). No partial word is pushed after reset asserts.
- Grant latency is 1 cycle: a request seen in IDLE at edge t gives BUSY and a possible push in cycle t+1.
- Every grant ends with one IDLE arbitration cycle.
  - Steady-state throughput without burst: 1 word per 2 cycles.
  - With burst: MAX_BURST words per MAX_BURST+1 cycles.
- o_push, o_ack and o_wdata are combinational from registered state plus i_req/i_full/i_data. There is no added push latency, so the FIFO's own full flag protects it from overflow.

## Configuration
- FIFO_WR_ARB_BURST_EN defined: an owner may push up to MAX_BURST consecutive words; bcnt width is clog2(MAX_BURST+1).
- Not defined: the limit is 1, so the grant rotates after every push. bcnt logic and the MAX_BURST parameter usage are compiled out.

## Structure
- Package fifo_arb_pkg holds:
  - the state encoding: IDLE=1'b0, BUSY=1'b1;
  - the clog2 helper function;
  - localparams for ptr/owner width and bcnt width.
- Sub-module rr_pick (combinational): inputs are the req vector and ptr; outputs are `found` and the winner index. It is instantiated once in the IDLE decision path.

## Test plan
- Single requester (NREQ=4, burst off): i_req=4'b0100 with data 0x0011 then 0x0022 → pushes 0x0011 and then 0x0022 two cycles apart, o_grant_id=2, o_ack=4'b0100 on each push.
- All requesting, burst off: i_req=4'b1111 held → grant order 0,1,2,3,0; each owner gets exactly one push; ptr wraps 3→0.
- Burst on, MAX_BURST=4: requesters 0 and 1 both requesting continuously → four pushes from 0, one IDLE cycle, then four pushes from 1.
- Full stall: during a burst, i_full=1 for 3 cycles → o_push=0 and o_ack=0 for those cycles, the grant is held and the remaining words push after i_full falls; no words are lost or duplicated.
- Simultaneous drop/full: i_req[owner] falls in the same cycle i_full rises → no push, IDLE next cycle, ptr = owner+1.
- Reset mid-burst: i_rst_n low after two of four burst words → o_push, o_ack and o_busy go to 0 immediately. After release, arbitration restarts from ptr=0 with requester 0 winning if requesting.
